fp_result_normalizer: RTL and testbench
=======================================

// Module: fp_result_normalizer
// PURPOSE
//  Back end of the FP adder datapath; the inverse of the mantissa-alignment stage. Accepts the
//  raw signed-magnitude sum (hidden bit at MSB-1, carry at MSB, 24 guard/sticky LSBs),
//  normalizes it (1 right or up to 47 left shifts, one per cycle), rounds to nearest-even
//  and packs an IEEE-754 result. Valid/ready on both sides; one operation in flight.
// PARAMETERS
//  FRAC_W  23  stored fraction bits; MW = 2*FRAC_W+3 = 49 sum width
//  EXP_W   8   biased exponent bits; EMAX = 2**EXP_W-1 = 255
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       operand presented
//  in_ready     out  1       block idle, capture on in_valid&in_ready
//  in_sign      in   1       result sign
//  in_exp       in   EXP_W   biased exp of larger operand, 1..EMAX-1 (denormal inputs use 1)
//  in_mant      in   MW      [48]=carry [47]=hidden [46:24]=frac [23]=guard [22:0]=sticky
//  out_valid    out  1       result valid, held until out_ready
//  out_ready    in   1       consumer accepts result
//  out_result   out  1+EXP_W+FRAC_W  {sign,exp,frac} packed result
//  out_overflow out  1       result saturated to infinity
//  out_inexact  out  1       guard|sticky nonzero at rounding
//  out_zero     out  1       in_mant was zero
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_result/flags=0, internal regs 0; in_ready=1 after reset.
//  Reset mid-operation aborts it; no output produced. in_ready = (state==IDLE), combinational.
//  Internal exponent EXP_W+2 bits unsigned (no wrap on +1 from EMAX-1).
//  IDLE: on in_valid&in_ready latch sign, exp, mant -> NORM. in_valid while busy ignored.
//  NORM (one decision per cycle, priority order):
//   mant==0          -> result {sign,0,0}, out_zero=1, -> DONE
//   mant[48]         -> mant = mant>>1 with new[0]=old[1]|old[0] (sticky kept); exp+1; -> ROUND
//   mant[47]         -> ROUND
//   exp==1           -> ROUND (denormal result, no further shift)
//   else             -> mant<<=1, exp-=1, stay NORM
//  ROUND (one cycle): G=mant[23], S=|mant[22:0], L=mant[24]; up=G&(S|L); out_inexact=G|S
//   sig = {mant[47],mant[46:24]} + up (25 bits)
//   sig[24] -> e=exp+1, frac=0 ; sig[23] -> e=exp, frac=sig[22:0] ; else e=0, frac=sig[22:0]
//   e>=EMAX -> out_result={sign,EMAX,0}, out_overflow=1 ; else {sign,e[EXP_W-1:0],frac}
//   -> DONE
//  DONE: out_valid=1; out_result/flags stable; on out_ready -> IDLE (out_valid 0 next cycle).
//   Flags cleared at next capture.
//  Latency capture-edge -> out_valid: 3 cycles + k left shifts (k<=47, worst 50).
//  Throughput: next capture earliest the cycle after DONE handshake.
// TESTING
//  T1 carry: exp=127, mant=49'h1_0000_0000_0000 -> 0x40000000, out_valid 3 cycles after capture
//  T2 cancel: exp=127, mant=2^24 -> 23 shifts, 0x34000000, latency 26
//  T3 RNE: mant=2^47|2^23 -> 0x3F800000 inexact=1; mant=2^47|2^24|2^23 -> 0x3F800002
//  T4 round carry: exp=127, mant=49'h0_FFFF_FF80_0000 -> 0x40000000; exp=254, mant=2^48 ->
//     0x7F800000 overflow=1
//  T5 denormal/zero: exp=3, mant=2^44 -> 0x00400000; sign=1, mant=0 -> 0x80000000, zero=1
//  T6 control: out_ready=0 5 cycles -> result stable, in_ready=0; rst during NORM ->
//     out_valid=0, in_ready=1

Source files
------------

// File: rtl/fp_result_normalizer.sv
// fp_result_normalizer: normalizes a raw FP adder sum one shift per cycle,
// rounds to nearest-even and packs an IEEE-754 result behind valid/ready.
module fp_result_normalizer #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [2*FRAC_W+2:0]       in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_overflow,
    output logic                      out_inexact,
    output logic                      out_zero
);
    localparam int MW = 2*FRAC_W+3;
    localparam int XW = EXP_W+2;
    localparam logic [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t           state;
    logic             sign_r;
    logic [XW-1:0]    exp_r;
    logic [MW-1:0]    mant_r;
    logic             g, s, l, up;
    logic [FRAC_W+1:0] sig;
    logic [XW-1:0]    e;
    logic [FRAC_W-1:0] frac;
    assign in_ready = (state == IDLE);
    // Rounding view of the normalized mantissa: 24-bit significand above the guard bit.
    always_comb begin
        g    = mant_r[FRAC_W];
        s    = |mant_r[FRAC_W-1:0];
        l    = mant_r[FRAC_W+1];
        up   = g & (s | l);
        sig  = {1'b0, mant_r[2*FRAC_W+1:FRAC_W+1]} + (FRAC_W+2)'(up);
        e    = sig[FRAC_W+1] ? exp_r + XW'(1) : sig[FRAC_W] ? exp_r : '0;
        frac = sig[FRAC_W+1] ? '0 : sig[FRAC_W-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sign_r       <= 1'b0;
            exp_r        <= '0;
            mant_r       <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_r       <= in_sign;
                    exp_r        <= XW'(in_exp);
                    mant_r       <= in_mant;
                    out_overflow <= 1'b0;
                    out_inexact  <= 1'b0;
                    out_zero     <= 1'b0;
                    state        <= NORM;
                end
                NORM: if (mant_r == '0) begin
                    out_result <= {sign_r, {(EXP_W+FRAC_W){1'b0}}};
                    out_zero   <= 1'b1;
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end else if (mant_r[MW-1]) begin
                    // Carry out: the bit shifted off is folded into sticky.
                    mant_r <= {1'b0, mant_r[MW-1:2], mant_r[1] | mant_r[0]};
                    exp_r  <= exp_r + XW'(1);
                    state  <= ROUND;
                end else if (mant_r[MW-2] || exp_r == XW'(1)) begin
                    state <= ROUND;
                end else begin
                    mant_r <= mant_r << 1;
                    exp_r  <= exp_r - XW'(1);
                end
                ROUND: begin
                    out_inexact  <= g | s;
                    out_overflow <= (e >= EMAX);
                    out_result   <= (e >= EMAX) ? {sign_r, EMAX[EXP_W-1:0], {FRAC_W{1'b0}}}
                                                : {sign_r, e[EXP_W-1:0], frac};
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_result_normalizer.sv
// tb_fp_result_normalizer: directed vectors checked against an arithmetic
// reference model plus literal expected results.
module tb_fp_result_normalizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [48:0] in_mant = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow, out_inexact, out_zero;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_res;
    logic        m_ov, m_ix, m_z;
    int          m_lat;
    int          age = 0;
    bit          seen = 0;
    bit          live = 0;

    fp_result_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_inexact(out_inexact), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, x);
        end
    endfunction

    // Reference: find leading one, shift as far as the exponent floor allows,
    // then round the 24-bit significand by comparing the remainder to one half.
    function automatic void model(input logic sg, input int ein, input logic [48:0] min,
                                  output logic [31:0] r, output logic ov, output logic ix,
                                  output logic z, output int lat);
        logic [48:0] m;
        int ex, k, msb;
        longint keep, rem;
        m = min; ex = ein; ov = 0; ix = 0; z = 0; k = 0; msb = 0;
        if (m == 0) begin
            r = {sg, 31'b0}; z = 1; lat = 2;
            return;
        end
        if (m[48]) begin
            m = (m >> 1) | (m & 49'd1);
            ex = ex + 1;
        end else begin
            for (int i = 0; i < 48; i++) if (m[i]) msb = i;
            k = 47 - msb;
            if (k > ex - 1) k = ex - 1;
            m = m << k;
            ex = ex - k;
        end
        lat = 3 + k;
        keep = longint'(m[47:24]);
        rem  = longint'(m[23:0]);
        ix = (rem != 0);
        if (rem > (64'd1 << 23) || (rem == (64'd1 << 23) && keep[0])) keep = keep + 1;
        if (keep >= (64'd1 << 24)) begin ex = ex + 1; keep = 0; end
        else if (keep < (64'd1 << 23)) ex = 0;
        if (ex >= 255) begin r = {sg, 8'hFF, 23'b0}; ov = 1; end
        else r = {sg, ex[7:0], keep[22:0]};
    endfunction

    always @(negedge clk) begin
        if (live) begin
            age++;
            if (out_valid) begin
                chk("result", out_result, m_res);
                chk("flags", {out_overflow, out_inexact, out_zero}, {m_ov, m_ix, m_z});
                if (!seen) chk("latency", age, m_lat);
                seen = 1;
            end else if (seen) chk("valid_held", out_valid, 1);
        end
    end

    task automatic op(input logic sg, input logic [7:0] e, input logic [48:0] m,
                      input logic [31:0] lit, input int hold);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_sign = sg; in_exp = e; in_mant = m; in_valid = 1;
        model(sg, int'(e), m, m_res, m_ov, m_ix, m_z, m_lat);
        @(posedge clk);
        #1 in_valid = 0; age = 0; seen = 0; live = 1;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            #1;
        end
        if (!seen) chk("timeout", 0, 1);
        chk("literal", out_result, lit);
        if (hold > 0) begin
            in_valid = 1; in_exp = 8'd5; in_mant = '1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                #1 chk("busy_in_ready", in_ready, 0);
            end
            in_valid = 0;
        end
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0; live = 0;
        @(negedge clk);
        chk("released", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_out", {out_valid, out_result, out_overflow, out_inexact, out_zero}, 0);
        chk("reset_ready", in_ready, 1);
        rst = 0;
        op(0, 8'd127, 49'h1_0000_0000_0000, 32'h40000000, 0);
        op(0, 8'd127, 49'd1 << 24, 32'h34000000, 0);
        op(0, 8'd127, (49'd1 << 47) | (49'd1 << 23), 32'h3F800000, 0);
        op(0, 8'd127, (49'd1 << 47) | (49'd1 << 24) | (49'd1 << 23), 32'h3F800002, 0);
        op(0, 8'd127, 49'h0_FFFF_FF80_0000, 32'h40000000, 0);
        op(0, 8'd254, 49'd1 << 48, 32'h7F800000, 0);
        op(0, 8'd3, 49'd1 << 44, 32'h00400000, 0);
        op(1, 8'd100, 49'd0, 32'h80000000, 0);
        op(1, 8'd130, (49'd1 << 47) | (49'd1 << 30), 32'hC1000040, 5);
        op(0, 8'd127, (49'd1 << 48) | 49'd1, 32'h40000000, 0);
        op(0, 8'd127, (49'd1 << 48) | (49'd1 << 24) | 49'd1, 32'h40000001, 0);
        op(0, 8'd1, 49'd1 << 30, 32'h00000040, 0);
        @(negedge clk);
        in_valid = 1; in_exp = 8'd127; in_mant = 49'd1 << 24;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (5) @(negedge clk);
        chk("norm_busy", in_ready, 0);
        rst = 1;
        #1 chk("rst_abort", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        chk("no_output_after_abort", out_valid, 0);
        op(1, 8'd127, 49'h1_0000_0000_0000, 32'hC0000000, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
